// File: rtl/sme_pkg.sv
// Shared constants and types for the string-match engine front-end and its benches.
package sme_pkg;

  localparam int STR_MAX = 32;   // string buffer depth in bytes
  localparam int STR_IW  = 5;    // string index width
  localparam int STR_LW  = 6;    // string length width (0..STR_MAX)
  localparam int PAT_MAX = 8;    // pattern buffer depth in bytes
  localparam int PAT_IW  = 3;    // pattern index width
  localparam int PAT_LW  = 4;    // pattern length width (0..PAT_MAX)
  localparam int TIMEOUT = 255;  // cycles allowed in WAIT_RES before aborting
  localparam int TIMER_W = 8;    // wide enough to hold TIMEOUT

  typedef enum logic [2:0] {
    LOAD,
    SEND_STR,
    SEND_PAT,
    WAIT_RES,
    REPORT
  } state_t;

  // Characters with special meaning to the match engine
  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/sme_byte_buf.sv
// Byte buffer with write pointer, length latch on the last byte, overflow strobe
// and an asynchronous read port that forwards a same-cycle write.
module sme_byte_buf #(
  parameter int DEPTH = 32,
  parameter int IW    = 5,
  parameter int LW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  input  logic          restart,   // this write starts over at index 0
  input  logic          clear,     // drop pointer and length
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] len,
  output logic          ovf        // a byte was dropped this cycle
);

  logic [7:0]    mem [DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] base;
  logic          full;

  assign base = restart ? '0 : wr_ptr;
  assign full = (base == LW'(DEPTH));
  assign ovf  = wr_en && full;

  // Forward a byte being written this cycle so a one-byte segment can be
  // replayed on the very next cycle.
  assign rd_data = (wr_en && !full && (base[IW-1:0] == rd_idx)) ? wr_data : mem[rd_idx];

  // Storage write; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[base[IW-1:0]] <= wr_data;
    end
  end

  // Write pointer and length bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      len    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      len    <= '0;
    end else if (wr_en) begin
      wr_ptr <= full ? base : base + 1'b1;
      if (wr_last) begin
        len <= full ? LW'(DEPTH) : base + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sme_feeder.sv
// Host-side feeder for the string-match engine: buffers one job, replays it
// to the engine, waits for the engine result and hands it back to the host.
module sme_feeder
  import sme_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  state_t              state;
  logic [STR_LW-1:0]   send_idx;
  logic [TIMER_W-1:0]  timer;
  logic                new_str;
  logic                err;

  logic                str_we;
  logic                pat_we;
  logic                str_drop;
  logic                pat_drop;
  logic                pat_clear;
  logic [7:0]          str_rd;
  logic [7:0]          pat_rd;
  logic [STR_LW-1:0]   str_len;
  logic [PAT_LW-1:0]   pat_len;
  logic [STR_IW-1:0]   str_ridx;
  logic [PAT_IW-1:0]   pat_ridx;

  // in_ready is only high in LOAD, so it also gates buffer writes
  assign str_we    = in_valid && in_ready && !in_type;
  assign pat_we    = in_valid && in_ready && in_type;
  assign pat_clear = (state == REPORT) && res_ready;
  assign str_ridx  = (state == SEND_STR) ? send_idx[STR_IW-1:0] : '0;
  assign pat_ridx  = (state == SEND_PAT) ? send_idx[PAT_IW-1:0] : '0;

  // The first string byte of a job (new_str still clear) rewrites from index 0;
  // the string length survives across jobs for pattern-only reuse.
  sme_byte_buf #(.DEPTH(STR_MAX), .IW(STR_IW), .LW(STR_LW)) u_str_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (str_we),
    .wr_data (in_data),
    .wr_last (in_last),
    .restart (!new_str),
    .clear   (1'b0),
    .rd_idx  (str_ridx),
    .rd_data (str_rd),
    .len     (str_len),
    .ovf     (str_drop)
  );

  sme_byte_buf #(.DEPTH(PAT_MAX), .IW(PAT_IW), .LW(PAT_LW)) u_pat_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pat_we),
    .wr_data (in_data),
    .wr_last (in_last),
    .restart (1'b0),
    .clear   (pat_clear),
    .rd_idx  (pat_ridx),
    .rd_data (pat_rd),
    .len     (pat_len),
    .ovf     (pat_drop)
  );

  // Job sequencer with registered engine and host outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      chardata  <= '0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err   <= 1'b0;
      new_str   <= 1'b0;
      err       <= 1'b0;
      timer     <= '0;
      send_idx  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (str_we) new_str <= 1'b1;
          if (str_drop || pat_drop) err <= 1'b1;
          if (pat_we && in_last) begin
            in_ready <= 1'b0;
            new_str  <= 1'b0;
            if (str_len == '0) begin
              // Nothing to search in: fail the job straight away
              state     <= REPORT;
              res_valid <= 1'b1;
              res_match <= 1'b0;
              res_index <= '0;
              res_err   <= 1'b1;
            end else if (new_str) begin
              state    <= SEND_STR;
              chardata <= str_rd;
              isstring <= 1'b1;
              send_idx <= STR_LW'(1);
            end else begin
              state     <= SEND_PAT;
              chardata  <= pat_rd;
              ispattern <= 1'b1;
              send_idx  <= STR_LW'(1);
            end
          end
        end
        SEND_STR: begin
          if (send_idx < str_len) begin
            chardata <= str_rd;
            send_idx <= send_idx + 1'b1;
          end else begin
            // Pattern starts on the cycle right after the last string byte
            state     <= SEND_PAT;
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_rd;
            send_idx  <= STR_LW'(1);
          end
        end
        SEND_PAT: begin
          if (send_idx < STR_LW'(pat_len)) begin
            chardata <= pat_rd;
            send_idx <= send_idx + 1'b1;
          end else begin
            state     <= WAIT_RES;
            ispattern <= 1'b0;
            chardata  <= '0;
            timer     <= '0;
          end
        end
        WAIT_RES: begin
          if (sme_valid) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_match <= sme_match;
            res_index <= sme_index;
            res_err   <= err;
          end else if (timer == TIMER_W'(TIMEOUT)) begin
            state     <= REPORT;
            res_valid <= 1'b1;
            res_match <= 1'b0;
            res_index <= '0;
            res_err   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state     <= LOAD;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            res_match <= 1'b0;
            res_index <= '0;
            res_err   <= 1'b0;
            err       <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// Self-checking bench for sme_feeder: expected engine bytes and host results are
// queued when a job is driven and compared as the feeder produces them.
module tb_sme_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_type = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid = 1'b0;
  logic       sme_match = 1'b0;
  logic [4:0] sme_index = 5'd0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;

  typedef struct packed {
    logic       m;
    logic [4:0] ix;
    logic       e;
  } res_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         t_last = 0;
  int         str_have = 0;
  int         n_is = 0;
  int         n_ip = 0;
  int         first_cyc = 0;
  int         last_cyc = 0;
  bit         prev_act = 1'b0;
  logic [9:0] eng_q[$];
  res_t       res_q[$];

  sme_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_type   (in_type),
    .in_last   (in_last),
    .chardata  (chardata),
    .isstring  (isstring),
    .ispattern (ispattern),
    .sme_valid (sme_valid),
    .sme_match (sme_match),
    .sme_index (sme_index),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_match (res_match),
    .res_index (res_index),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Engine-side monitor: every replayed byte must match the head of the queue
  always @(negedge clk) begin
    if (!reset && (isstring || ispattern)) begin
      if (!prev_act) first_cyc = cyc;
      last_cyc = cyc;
      prev_act = 1'b1;
      if (isstring) n_is++;
      else          n_ip++;
      if (eng_q.size() == 0) check("eng_extra", {isstring, ispattern, chardata}, 10'h000);
      else                   check("eng_byte", {isstring, ispattern, chardata}, eng_q.pop_front());
    end else begin
      prev_act = 1'b0;
    end
  end

  task automatic send_seg(input string t, input bit typ);
    for (int k = 0; k < t.len(); k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = t[k];
      in_type  = typ;
      in_last  = (k == t.len() - 1);
      if (in_last) t_last = cyc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_job(input string s, input string p, input bit respond,
                        input bit m, input logic [4:0] ix, input int hold);
    int   ns;
    int   np;
    int   w;
    int   b_is;
    int   b_ip;
    bit   e;
    bit   live;
    res_t r;
    ns = (s.len() > 32) ? 32 : s.len();
    np = (p.len() > 8) ? 8 : p.len();
    if (s.len() > 0) str_have = ns;
    e    = (s.len() > 32) || (p.len() > 8);
    live = (str_have > 0);
    b_is = n_is;
    b_ip = n_ip;
    if (!live) begin
      r = {1'b0, 5'd0, 1'b1};
    end else begin
      for (int k = 0; k < ns; k++) eng_q.push_back({2'b10, s[k]});
      for (int k = 0; k < np; k++) eng_q.push_back({2'b01, p[k]});
      r = respond ? {m, ix, e} : {1'b0, 5'd0, 1'b1};
    end
    res_q.push_back(r);

    if (s.len() > 0) send_seg(s, 1'b0);
    send_seg(p, 1'b1);

    for (w = 0; w < 200 && (eng_q.size() != 0 || isstring || ispattern); w++) @(negedge clk);
    check("stream_done", eng_q.size(), 0);
    if (live) begin
      check("str_cycles", n_is - b_is, (s.len() > 0) ? ns : 0);
      check("pat_cycles", n_ip - b_ip, np);
      check("first_lat", first_cyc, t_last + 1);
      check("no_gap", last_cyc - first_cyc + 1, ((s.len() > 0) ? ns : 0) + np);
    end

    if (respond && live) begin
      @(negedge clk);
      sme_valid = 1'b1;
      sme_match = m;
      sme_index = ix;
      @(negedge clk);
      sme_valid = 1'b0;
      sme_match = ~m;
      sme_index = ~ix;
    end

    for (w = 0; w < 400 && !res_valid; w++) @(negedge clk);
    check("res_valid", res_valid, 1);
    if (respond && live) check("res_lat", w, 0);
    if (res_valid && res_q.size() > 0) begin
      r = res_q.pop_front();
      check("res_match", res_match, r.m);
      check("res_index", res_index, r.ix);
      check("res_err", res_err, r.e);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", {res_match, res_index, res_err}, r);
      check("hold_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_valid", res_valid, 0);
    check("post_in_ready", in_ready, 1);
    $display("job str=\"%s\" pat=\"%s\" -> match=%0d index=%0d err=%0d (exp %0d/%0d/%0d)",
             s, p, res_match, res_index, res_err, r.m, r.ix, r.e);
  endtask

  task automatic reset_mid_job();
    int w;
    for (int k = 0; k < 6; k++) eng_q.push_back({2'b10, 8'h61 + 8'(k)});
    for (int k = 0; k < 3; k++) eng_q.push_back({2'b01, 8'h78 + 8'(k)});
    send_seg("abcdef", 1'b0);
    send_seg("xyz", 1'b1);
    for (w = 0; w < 50 && !ispattern; w++) @(negedge clk);
    check("rst_saw_pat", ispattern, 1);
    reset = 1'b1;
    #1;
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_in_ready", in_ready, 1);
    eng_q.delete();
    res_q.delete();
    str_have = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sme_valid = 1'b1;
    sme_match = 1'b1;
    @(negedge clk);
    sme_valid = 1'b0;
    sme_match = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_result", res_valid, 0);
    $display("job reset during SEND_PAT -> res_valid=%0d in_ready=%0d", res_valid, in_ready);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_outs", {isstring, ispattern, res_valid, res_match, res_index, res_err, chardata}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_job("", "ab", 1'b0, 1'b0, 5'd0, 0);                                     // no string yet
    do_job("hello world", "wor", 1'b1, 1'b1, 5'd6, 0);
    do_job("", "^he", 1'b1, 1'b1, 5'd0, 0);                                    // reuse string
    do_job("abcdefghijklmnopqrstuvwxyz01234567", "ab", 1'b1, 1'b1, 5'd5, 0);   // string overflow
    do_job("xyz", "abcdefghij", 1'b1, 1'b0, 5'd0, 0);                          // pattern overflow
    do_job("abc", "b", 1'b0, 1'b0, 5'd0, 0);                                   // engine timeout
    do_job("", "c", 1'b1, 1'b1, 5'd2, 10);                                     // slow host
    reset_mid_job();
    do_job("", "q", 1'b0, 1'b0, 5'd0, 0);                                      // string lost by reset
    do_job("q", "q", 1'b1, 1'b1, 5'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
